// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator.
//  - cic_acc_width(): register width that holds the full CIC gain without overflow
//  - DS_POS / DS_NEG: 2-bit signed encodings of the modulator bit
//  - dec_cnt_t: decimation counter type, wide enough for the largest supported R (1024)
package cic_pkg;

  localparam logic signed [1:0] DS_POS = 2'sb01;
  localparam logic signed [1:0] DS_NEG = 2'sb11;

  localparam int unsigned DEC_CNT_W = $clog2(1024);
  typedef logic [DEC_CNT_W-1:0] dec_cnt_t;

  // Sign bit + unit input magnitude + log2 of the (R*M)^N gain.
  function automatic int unsigned cic_acc_width(input int unsigned n, input int unsigned r,
                                                input int unsigned m);
    return 2 + n * $clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator: data_o = data_i - data_i delayed by M decimated samples.
// State (output register and delay line) only advances when valid_i is high; valid_o is
// valid_i delayed by one clock so the strobe travels alongside the data.
// Ports:
//  clk      in   rising-edge clock
//  rst_n    in   asynchronous active-low reset
//  data_i   in   Width  sample from previous stage (modulo 2^Width)
//  valid_i  in   1      data_i carries a decimated sample this cycle
//  data_o   out  Width  differentiated sample
//  valid_o  out  1      data_o was updated on the last edge
module cic_comb_stage #(
  parameter int unsigned Width = 26,
  parameter int unsigned M     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] data_i,
  input  logic             valid_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o
);

  logic [Width-1:0] dly_q [M];
  logic [Width-1:0] dly_d [M];
  logic [Width-1:0] out_q, out_d;
  logic             valid_q;

  always_comb begin
    dly_d = dly_q;
    out_d = out_q;
    if (valid_i) begin
      out_d    = data_i - dly_q[M-1];
      dly_d[0] = data_i;
      for (int j = 1; j < int'(M); j++) begin
        dly_d[j] = dly_q[j-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(M); j++) begin
        dly_q[j] <= '0;
      end
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      out_q   <= out_d;
      valid_q <= valid_i;
    end
  end

  assign data_o  = out_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: 1-bit sigma-delta bitstream in, decimated signed PCM samples out,
// one single-cycle out_valid strobe per R accepted input bits. Output latency is N+2 edges
// after the edge that accepts the R-th bit (strobe register, capture register, N combs,
// output register).
// Optional feature: define CIC_GAIN_NORM_EN to MSB-align the result as Q1.(OUT_WIDTH-1) with
// saturation; otherwise data_out is the raw comb output (gain (R*M)^N) sign-extended.
// Ports:
//  clk        in   rising-edge clock
//  rst_n      in   asynchronous active-low reset; discards any partial frame
//  ds_in      in   modulator bit, 1 -> +1, 0 -> -1
//  ds_valid   in   ds_in accepted on this edge
//  data_out   out  OUT_WIDTH signed decimated sample, held between strobes
//  out_valid  out  one-cycle strobe marking a new data_out
module cic_decimator
  import cic_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned R         = 64,
  parameter int unsigned M         = 1,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ds_in,
  input  logic                 ds_valid,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 out_valid
);

  localparam int unsigned AccWidth = cic_acc_width(N, R, M);
  localparam int unsigned GainBits = AccWidth - 2;
  localparam dec_cnt_t    CntLast  = dec_cnt_t'(R - 1);

  if (R < 4 || R > 1024 || (R & (R - 1)) != 0) begin : g_bad_r
    $error("cic_decimator: R must be a power of two in 4..1024");
  end
  if (N < 1 || N > 8 || M < 1 || M > 2) begin : g_bad_nm
    $error("cic_decimator: N must be 1..8 and M must be 1 or 2");
  end
`ifndef CIC_GAIN_NORM_EN
  if (OUT_WIDTH < AccWidth) begin : g_bad_w
    $error("cic_decimator: OUT_WIDTH must be >= accumulator width for raw output");
  end
`endif

  // ---------------------------------------------------------------------------------------------
  // Integrators and decimation counter
  // ---------------------------------------------------------------------------------------------
  logic [AccWidth-1:0] integ_q [N];
  logic [AccWidth-1:0] integ_d [N];
  logic signed [1:0]   ds_sym;
  dec_cnt_t            cnt_q, cnt_d;
  logic                dec_stb_q, dec_stb_d;

  always_comb begin
    ds_sym    = ds_in ? DS_POS : DS_NEG;
    integ_d   = integ_q;
    cnt_d     = cnt_q;
    dec_stb_d = 1'b0;
    if (ds_valid) begin
      // All stages use pre-edge values, so each integrator adds one cycle of pipeline delay;
      // modulo wrap is intentional and cancels in the combs.
      integ_d[0] = integ_q[0] + AccWidth'(ds_sym);
      for (int k = 1; k < int'(N); k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      if (cnt_q == CntLast) begin
        cnt_d     = '0;
        dec_stb_d = 1'b1;
      end else begin
        cnt_d = cnt_q + dec_cnt_t'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Capture into the comb pipeline one edge after the strobe is registered, so the sampled
  // integrator value includes the R-th bit.
  // ---------------------------------------------------------------------------------------------
  logic [AccWidth-1:0] cap_q, cap_d;
  logic                cap_vld_q;

  always_comb begin
    cap_d = dec_stb_q ? integ_q[N-1] : cap_q;
  end

  logic [AccWidth-1:0] comb_data [N+1];
  logic [N:0]          comb_vld;

  assign comb_data[0] = cap_q;
  assign comb_vld[0]  = cap_vld_q;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(
      .Width (AccWidth),
      .M     (M)
    ) u_comb (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (comb_data[k]),
      .valid_i (comb_vld[k]),
      .data_o  (comb_data[k+1]),
      .valid_o (comb_vld[k+1])
    );
  end

  // ---------------------------------------------------------------------------------------------
  // Output formatting
  // ---------------------------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] sample;

`ifdef CIC_GAIN_NORM_EN
  localparam int          NormShift = int'(OUT_WIDTH) - 1 - int'(GainBits);
  localparam int unsigned ShL       = (NormShift > 0) ? NormShift : 0;
  localparam int unsigned ShR       = (NormShift < 0) ? -NormShift : 0;
  localparam int unsigned WideW     = AccWidth + OUT_WIDTH;

  logic signed [WideW-1:0] wide;

  always_comb begin
    wide = WideW'(signed'(comb_data[N]));
    wide = (wide <<< ShL) >>> ShR;
    // In range only if every bit above the output sign bit matches it.
    if ((&wide[WideW-1:OUT_WIDTH-1]) || !(|wide[WideW-1:OUT_WIDTH-1])) begin
      sample = wide[OUT_WIDTH-1:0];
    end else if (wide[WideW-1]) begin
      sample = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sample = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    sample = OUT_WIDTH'(signed'(comb_data[N]));
  end
`endif

  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                 out_valid_q, out_valid_d;

  always_comb begin
    out_valid_d = comb_vld[N];
    data_out_d  = comb_vld[N] ? sample : data_out_q;
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N); k++) begin
        integ_q[k] <= '0;
      end
      cnt_q       <= '0;
      dec_stb_q   <= 1'b0;
      cap_q       <= '0;
      cap_vld_q   <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      cnt_q       <= cnt_d;
      dec_stb_q   <= dec_stb_d;
      cap_q       <= cap_d;
      cap_vld_q   <= dec_stb_q;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator with default parameters. The driver pushes the expected
// sample and the edge it must appear on; the monitor pops and compares on every out_valid.
module tb_cic_decimator;

  localparam int N   = 4;
  localparam int R   = 64;
  localparam int M   = 1;
  localparam int OW  = 32;
  localparam int AW  = 2 + N * $clog2(R * M);
  localparam int SH  = OW - 1 - N * $clog2(R * M);
  localparam int LAT = N + 2;

`ifdef CIC_GAIN_NORM_EN
  localparam logic [31:0] POS_SETTLED = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SETTLED = 32'h8000_0000;
`else
  localparam logic [31:0] POS_SETTLED = 32'h0100_0000;
  localparam logic [31:0] NEG_SETTLED = 32'hFF00_0000;
`endif

  logic          clk;
  logic          rst_n;
  logic          ds_in;
  logic          ds_valid;
  logic [OW-1:0] data_out;
  logic          out_valid;

  cic_decimator #(
    .N         (N),
    .R         (R),
    .M         (M),
    .OUT_WIDTH (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ds_in     (ds_in),
    .ds_valid  (ds_valid),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  int          spacing = 0;
  bit          gap_chk = 0;
  int          release_cyc = 0;
  logic [31:0] last_exp = '0;

  // Reference model state
  logic [AW-1:0] mi [N];
  logic [AW-1:0] md [N];
  int            mcnt;
  int            stb_idx;
  bit            use_const;
  logic [31:0]   const_val;

  function automatic logic [31:0] fmt(input logic [AW-1:0] v);
`ifdef CIC_GAIN_NORM_EN
    longint s;
    s = longint'(signed'(v));
    s = s <<< SH;
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
`else
    return 32'(signed'(v));
`endif
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      mi[k] = '0;
      md[k] = '0;
    end
    mcnt    = 0;
    stb_idx = 0;
  endtask

  // Called at the negedge before the posedge that accepts the bit.
  task automatic model_step(input bit d);
    logic [AW-1:0] x, v, c;
    exp_t          e;
    x = d ? AW'(1) : '1;
    for (int k = N - 1; k >= 1; k--) mi[k] = mi[k] + mi[k-1];
    mi[0] = mi[0] + x;
    mcnt++;
    if (mcnt == R) begin
      mcnt = 0;
      stb_idx++;
      v = mi[N-1];
      for (int k = 0; k < N; k++) begin
        c     = v - md[k];
        md[k] = v;
        v     = c;
      end
      e.data    = (use_const && stb_idx >= 5) ? const_val : fmt(v);
      e.edge_no = cyc + 1 + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input bit v, input bit d);
    ds_valid = v;
    ds_in    = d;
    if (v) model_step(d);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // One-cycle reset starting at a negedge; returns at the releasing negedge.
  task automatic do_reset();
    rst_n    = 1'b0;
    ds_valid = 1'b0;
    ds_in    = 1'b0;
    model_clear();
    sb.delete();
    last_exp = '0;
    #1;
    check("reset_data_async", data_out, '0);
    check("reset_valid_async", 32'(out_valid), '0);
    @(negedge clk);
    check("reset_data", data_out, '0);
    check("reset_valid", 32'(out_valid), '0);
    rst_n       = 1'b1;
    release_cyc = cyc;
  endtask

  task automatic drain();
    repeat (LAT + 4) drive(1'b0, 1'b0);
  endtask

  // Monitor
  int last_stb = -1;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        last_stb = -1;
      end else if (mon_en) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: out_valid at edge %0d data_out=%h, none required",
                     cyc, data_out);
          end else begin
            e = sb.pop_front();
            check("strobe_data", data_out, e.data);
            check("strobe_edge", 32'(cyc), 32'(e.edge_no));
            last_exp = e.data;
          end
          if (spacing != 0 && last_stb >= 0) begin
            check("strobe_spacing", 32'(cyc - last_stb), 32'(spacing));
          end
          if (gap_chk) begin
            check("release_to_strobe", 32'(cyc - release_cyc), 32'(R + LAT));
            gap_chk = 0;
          end
          last_stb = cyc;
        end else begin
          if (sb.size() > 0 && cyc > sb[0].edge_no) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_strobe: no out_valid, required at edge %0d data %h",
                     e.edge_no, e.data);
          end
          if (cyc % 16 == 0) check("hold_data", data_out, last_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at edge %0d, required to finish", cyc);
    $fatal(1, "timeout");
  end

  logic [14:0] lfsr = 15'h0001;
  function automatic logic [14:0] lfsr_next(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  initial begin
    rst_n    = 1'b1;
    ds_valid = 1'b0;
    ds_in    = 1'b0;
    model_clear();
    @(negedge clk);

    // Constant +1: settled raw gain 64^4
    use_const = 1; const_val = POS_SETTLED; spacing = R;
    do_reset();
    mon_en  = 1;
    gap_chk = 1;
    repeat (10 * R) drive(1'b1, 1'b1);
    drain();

    // Constant -1
    const_val = NEG_SETTLED;
    do_reset();
    gap_chk = 1;
    repeat (10 * R) drive(1'b1, 1'b0);
    drain();

    // Alternating 1,0: null at fs/2
    const_val = 32'h0000_0000;
    do_reset();
    gap_chk = 1;
    repeat (5 * R) begin
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b0);
    end
    drain();

    // Single frame latency: only strobe exactly LAT edges after the 64th bit
    use_const = 0;
    do_reset();
    gap_chk = 1;
    repeat (R) drive(1'b1, 1'b1);
    repeat (2 * R) drive(1'b0, 1'b1);

    // ds_valid gapping: half-rate input
    use_const = 1; const_val = POS_SETTLED; spacing = 2 * R;
    do_reset();
    repeat (10 * R) begin
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
    end
    drain();

    // Integrator wrap, then PRBS against the model, then mid-frame reset
    use_const = 0; spacing = R;
    do_reset();
    gap_chk = 1;
    repeat (10000) drive(1'b1, 1'b1);
    repeat (20 * R + 20) begin
      drive(1'b1, lfsr[14]);
      lfsr = lfsr_next(lfsr);
    end
    do_reset();
    gap_chk = 1;
    repeat (3 * R) begin
      drive(1'b1, lfsr[14]);
      lfsr = lfsr_next(lfsr);
    end
    drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
